// File: rtl/stats_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// stats_ctrl_pkg
// Shared types and constants for the flow statistics update controller.
//   - C_MATCH_ADDR_WIDTH / C_COUNTER_WIDTH : counter RAM geometry
//   - state_e : controller state (INIT zeroing sweep, RUN)
//   - slot_e  : what a pipeline slot carries (IDLE, HIT, HOST_RD, HOST_CLR)
//   - s1_t    : S1 pipeline register {kind, addr, wdata}
//   - cnt_inc : counter increment, wrapping by default; saturating when the
//               STATS_SATURATE_EN macro is defined.
// ----------------------------------------------------------------------------
package stats_ctrl_pkg;

    localparam int C_MATCH_ADDR_WIDTH = 11;
    localparam int C_COUNTER_WIDTH    = 32;

    typedef logic [C_MATCH_ADDR_WIDTH-1:0] addr_t;
    typedef logic [C_COUNTER_WIDTH-1:0]    cnt_t;

    typedef enum logic {
        INIT,
        RUN
    } state_e;

    typedef enum logic [1:0] {
        IDLE,
        HIT,
        HOST_RD,
        HOST_CLR
    } slot_e;

    typedef struct packed {
        slot_e kind;
        addr_t addr;
        cnt_t  wdata;
    } s1_t;

    // Slot kinds that write port A in S1.
    function automatic logic is_write(slot_e k);
        return (k == HIT) || (k == HOST_CLR);
    endfunction

    function automatic logic is_host(slot_e k);
        return (k == HOST_RD) || (k == HOST_CLR);
    endfunction

    function automatic cnt_t cnt_inc(cnt_t v);
`ifdef STATS_SATURATE_EN
        return (&v) ? v : cnt_t'(v + 1'b1);
`else
        return cnt_t'(v + 1'b1);
`endif
    endfunction

endpackage

// File: rtl/stats_host_arbiter.sv
// ----------------------------------------------------------------------------
// stats_host_arbiter
// Slot arbitration between the hit stream and the host port, with a wait
// counter that throttles hits once a host request has waited too long.
//   clk, reset    : clock, synchronous active-high reset
//   run_i         : controller is in RUN
//   hit_valid_i   : a hit is presented this cycle
//   host_req_i    : host request level (held until acknowledged)
//   hit_ready_o   : hit accepted if presented (never depends on hit_valid_i)
//   grant_o       : this cycle's slot goes to the host
// ----------------------------------------------------------------------------
module stats_host_arbiter #(
    parameter int C_HOST_WAIT_MAX = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic run_i,
    input  logic hit_valid_i,
    input  logic host_req_i,
    output logic hit_ready_o,
    output logic grant_o
);

    localparam int WW = $clog2(C_HOST_WAIT_MAX + 1);

    logic [WW-1:0] wait_q;
    logic          granted_q;
    logic          pending;

    // The request stays high during its ack cycle; the cycle right after a
    // grant must not grant again.
    assign pending     = host_req_i && !granted_q;
    assign hit_ready_o = run_i && !reset && (wait_q < WW'(C_HOST_WAIT_MAX));
    assign grant_o     = run_i && pending && !(hit_valid_i && hit_ready_o);

    always_ff @(posedge clk) begin
        if (reset) begin
            wait_q    <= '0;
            granted_q <= 1'b0;
        end else begin
            granted_q <= grant_o;
            if (grant_o)
                wait_q <= '0;
            else if (run_i && pending && (wait_q < WW'(C_HOST_WAIT_MAX)))
                wait_q <= wait_q + 1'b1;
        end
    end

endmodule

// File: rtl/statistics_update_ctrl.sv
// ----------------------------------------------------------------------------
// statistics_update_ctrl
// Read-modify-write sequencer for the dual-port flow statistics RAM.
// Port B reads in S0, port A writes in S1; one hit per cycle, host reads and
// read-and-clears interleaved, full RAM zeroing after reset.
//   clk, reset            : clock, synchronous active-high reset
//   hit_valid/addr/ready  : match-hit handshake
//   host_req/addr/clear   : host access request (held until host_ack)
//   host_ack/host_data    : one-cycle response with the pre-clear value
//   init_done             : zeroing sweep finished
//   ram_*                 : statistics RAM ports (B read-only, A write-only)
// Optional build macro: STATS_SATURATE_EN (saturating counters).
// ----------------------------------------------------------------------------
module statistics_update_ctrl
    import stats_ctrl_pkg::*;
#(
    parameter int C_HOST_WAIT_MAX = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          hit_valid,
    input  logic [C_MATCH_ADDR_WIDTH-1:0] hit_addr,
    output logic                          hit_ready,
    input  logic                          host_req,
    input  logic [C_MATCH_ADDR_WIDTH-1:0] host_addr,
    input  logic                          host_clear,
    output logic                          host_ack,
    output logic [C_COUNTER_WIDTH-1:0]    host_data,
    output logic                          init_done,
    output logic [C_MATCH_ADDR_WIDTH-1:0] ram_addra,
    output logic [C_MATCH_ADDR_WIDTH-1:0] ram_addrb,
    output logic                          ram_wea,
    output logic                          ram_web,
    output logic [C_COUNTER_WIDTH-1:0]    ram_dina,
    output logic [C_COUNTER_WIDTH-1:0]    ram_dinb,
    input  logic [C_COUNTER_WIDTH-1:0]    ram_douta,
    input  logic [C_COUNTER_WIDTH-1:0]    ram_doutb
);

    state_e state_q;
    addr_t  init_addr_q;
    slot_e  s1_kind_q;
    addr_t  s1_addr_q;
    s1_t    wr_q;          // write issued last cycle, kept for forwarding
    s1_t    wr_d;          // S1 slot resolved this cycle
    slot_e  s0_kind;
    addr_t  s0_addr;
    cnt_t   operand;
    logic   run;
    logic   grant;
    logic   unused_douta;

    assign run          = (state_q == RUN);
    assign ram_web      = 1'b0;
    assign ram_dinb     = '0;
    assign unused_douta = ^ram_douta;

    stats_host_arbiter #(
        .C_HOST_WAIT_MAX(C_HOST_WAIT_MAX)
    ) u_arb (
        .clk         (clk),
        .reset       (reset),
        .run_i       (run),
        .hit_valid_i (hit_valid),
        .host_req_i  (host_req),
        .hit_ready_o (hit_ready),
        .grant_o     (grant)
    );

    // S0 slot decode: an accepted hit beats a host grant.
    always_comb begin
        s0_kind = IDLE;
        s0_addr = '0;
        if (hit_valid && hit_ready) begin
            s0_kind = HIT;
            s0_addr = hit_addr;
        end else if (grant) begin
            s0_kind = host_clear ? HOST_CLR : HOST_RD;
            s0_addr = host_addr;
        end
    end

    // The RAM read for this S1 slot was issued while last cycle's write to
    // the same entry was in flight, so doutb is stale; take the written value.
    assign operand = (is_write(wr_q.kind) && (wr_q.addr == s1_addr_q)) ? wr_q.wdata : ram_doutb;

    always_comb begin
        wr_d.kind  = s1_kind_q;
        wr_d.addr  = s1_addr_q;
        wr_d.wdata = (s1_kind_q == HIT) ? cnt_inc(operand) : '0;
    end

    always_comb begin
        ram_addra = '0;
        ram_addrb = '0;
        ram_wea   = 1'b0;
        ram_dina  = '0;
        host_ack  = 1'b0;
        host_data = '0;
        init_done = 1'b0;
        if (!reset) begin
            if (state_q == INIT) begin
                ram_addra = init_addr_q;
                ram_wea   = 1'b1;
            end else begin
                init_done = 1'b1;
                ram_addrb = s0_addr;
                if (is_write(wr_d.kind)) begin
                    ram_addra = wr_d.addr;
                    ram_wea   = 1'b1;
                    ram_dina  = wr_d.wdata;
                end
                if (is_host(wr_d.kind)) begin
                    host_ack  = 1'b1;
                    host_data = operand;
                end
            end
        end
    end

    // Reset drops whatever sits in S1 and restarts the zeroing sweep.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= INIT;
            init_addr_q <= '0;
            s1_kind_q   <= IDLE;
            s1_addr_q   <= '0;
            wr_q        <= '0;
        end else begin
            case (state_q)
                INIT: begin
                    init_addr_q <= init_addr_q + 1'b1;
                    if (&init_addr_q)
                        state_q <= RUN;
                end
                default: state_q <= RUN;
            endcase
            s1_kind_q <= s0_kind;
            s1_addr_q <= s0_addr;
            wr_q      <= wr_d;
        end
    end

endmodule

// File: tb/tb_statistics_update_ctrl.sv
module tb_statistics_update_ctrl;
    import stats_ctrl_pkg::*;

    localparam int AW    = C_MATCH_ADDR_WIDTH;
    localparam int CW    = C_COUNTER_WIDTH;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          hit_valid = 1'b0;
    logic [AW-1:0] hit_addr = '0;
    logic          hit_ready;
    logic          host_req = 1'b0;
    logic [AW-1:0] host_addr = '0;
    logic          host_clear = 1'b0;
    logic          host_ack;
    logic [CW-1:0] host_data;
    logic          init_done;
    logic [AW-1:0] ram_addra, ram_addrb;
    logic          ram_wea, ram_web;
    logic [CW-1:0] ram_dina, ram_dinb;
    logic [CW-1:0] ram_douta, ram_doutb;

    always #5 clk = ~clk;

    statistics_update_ctrl #(.C_HOST_WAIT_MAX(16)) dut (
        .clk(clk), .reset(reset),
        .hit_valid(hit_valid), .hit_addr(hit_addr), .hit_ready(hit_ready),
        .host_req(host_req), .host_addr(host_addr), .host_clear(host_clear),
        .host_ack(host_ack), .host_data(host_data), .init_done(init_done),
        .ram_addra(ram_addra), .ram_addrb(ram_addrb),
        .ram_wea(ram_wea), .ram_web(ram_web),
        .ram_dina(ram_dina), .ram_dinb(ram_dinb),
        .ram_douta(ram_douta), .ram_doutb(ram_doutb)
    );

    // Statistics RAM model: read-first, one-cycle read latency, plus a
    // bench-side preload port.
    logic [CW-1:0] mem [DEPTH];
    logic          pl_en = 1'b0;
    logic [AW-1:0] pl_addr = '0;
    logic [CW-1:0] pl_val = '0;

    always @(posedge clk) begin
        if (ram_wea) mem[ram_addra] <= ram_dina;
        if (pl_en)   mem[pl_addr]   <= pl_val;
        ram_doutb <= mem[ram_addrb];
        ram_douta <= mem[ram_addra];
    end

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [AW-1:0] a, input logic [CW-1:0] v);
        pl_en = 1'b1; pl_addr = a; pl_val = v;
        step();
        pl_en = 1'b0;
    endtask

    // Call right after reset is released; counts INIT cycles and checks the sweep.
    task automatic do_init(input string tag);
        int n;
        bit bad, ack;
        n = 0; bad = 0; ack = 0;
        for (int i = 0; i < DEPTH + 20; i++) begin
            @(negedge clk);
            if (host_ack) ack = 1;
            if (init_done) break;
            if (!ram_wea || ram_dina != '0 || ram_addra != AW'(n)) bad = 1;
            n++;
            step();
        end
        chk({tag, "_cycles"}, 64'(n), 64'(DEPTH));
        chk({tag, "_sweep"}, 64'(bad), 64'd0);
        chk({tag, "_hit_ready"}, 64'(hit_ready), 64'd1);
        chk({tag, "_no_ack"}, 64'(ack), 64'd0);
        step();
    endtask

    // Issue a host request and wait (bounded) for host_ack; lat = cycles
    // from request to ack, -1 on timeout.
    task automatic host_op(input logic [AW-1:0] a, input logic clr,
                           output logic [CW-1:0] d, output int lat);
        host_req = 1'b1; host_addr = a; host_clear = clr;
        d = '0; lat = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (host_ack) begin
                d = host_data; lat = i;
                break;
            end
            step();
        end
        step();
        host_req = 1'b0; host_clear = 1'b0;
    endtask

    task automatic host_rd_chk(input string tag, input logic [AW-1:0] a, input logic [CW-1:0] exp);
        logic [CW-1:0] d;
        int lat;
        host_op(a, 1'b0, d, lat);
        chk({tag, "_data"}, 64'(d), 64'(exp));
        chk({tag, "_lat"}, 64'(lat), 64'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [CW-1:0] d;
        int lat, low, nz;
        logic [CW-1:0] sat_exp;

        // ---------------- reset values
        repeat (3) step();
        @(negedge clk);
        chk("rst_hit_ready", 64'(hit_ready), 0);
        chk("rst_host_ack", 64'(host_ack), 0);
        chk("rst_host_data", 64'(host_data), 0);
        chk("rst_init_done", 64'(init_done), 0);
        chk("rst_wea_web", {62'd0, ram_wea, ram_web}, 0);
        chk("rst_addr", {ram_addra, ram_addrb}, 0);
        chk("rst_dina", 64'(ram_dina), 0);
        step();
        reset = 1'b0;
        do_init("init");

        // ---------------- idle read after zeroing
        host_rd_chk("rd5", 5, 0);

        // ---------------- back-to-back hits to 7: forwarding gives 1,2,3
        for (int i = 0; i < 4; i++) begin
            hit_valid = (i < 3); hit_addr = 7;
            @(negedge clk);
            if (i == 0) chk("fwd_ready", 64'(hit_ready), 1);
            if (i > 0) begin
                chk($sformatf("fwd_dina%0d", i), 64'(ram_dina), 64'(i));
                chk($sformatf("fwd_wr%0d", i), {51'd0, ram_wea, ram_addra}, {51'd0, 1'b1, 11'd7});
            end
            step();
        end
        host_rd_chk("rd7", 7, 3);

        // ---------------- continuous hits to 9 while host reads 4 (=10)
        preload(4, 10);
        hit_valid = 1'b1; hit_addr = 9; low = 0;
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    @(negedge clk);
                    if (!hit_ready) low++;
                end
            end
            host_op(4, 1'b0, d, lat);
        join
        step();
        hit_valid = 1'b0;
        chk("starve_low_cycles", 64'(low), 1);
        chk("starve_lat_le18", 64'(lat >= 0 && lat <= 18), 1);
        chk("starve_data", 64'(d), 10);
        // 40 cycles offered, one throttled; last hit still in S1 when read starts
        host_rd_chk("rd9", 9, 39);

        // ---------------- clear of 3 (=5) followed by a hit to 3
        preload(3, 5);
        host_req = 1'b1; host_addr = 3; host_clear = 1'b1;
        @(negedge clk);
        chk("clr_grant_noack", 64'(host_ack), 0);
        step();
        hit_valid = 1'b1; hit_addr = 3;
        @(negedge clk);
        chk("clr_ack", 64'(host_ack), 1);
        chk("clr_data", 64'(host_data), 5);
        chk("clr_hit_ready", 64'(hit_ready), 1);
        step();
        host_req = 1'b0; host_clear = 1'b0; hit_valid = 1'b0;
        @(negedge clk);
        chk("clr_single_ack", 64'(host_ack), 0);
        chk("clr_hit_dina", {31'd0, ram_wea, ram_dina}, {31'd0, 1'b1, 32'd1});
        step();
        host_rd_chk("rd3", 3, 1);

        // ---------------- all-ones counter increment
`ifdef STATS_SATURATE_EN
        sat_exp = '1;
`else
        sat_exp = '0;
`endif
        preload(2, '1);
        hit_valid = 1'b1; hit_addr = 2;
        step();
        hit_valid = 1'b0;
        @(negedge clk);
        chk("wrap_wr", {51'd0, ram_wea, ram_addra}, {51'd0, 1'b1, 11'd2});
        chk("wrap_dina", 64'(ram_dina), 64'(sat_exp));
        step();
        host_rd_chk("rd2", 2, sat_exp);

        // ---------------- reset in the ack cycle of a pending clear
        preload(6, 5);
        host_req = 1'b1; host_addr = 6; host_clear = 1'b1;
        hit_valid = 1'b1; hit_addr = 8;
        step();
        hit_valid = 1'b0;
        @(negedge clk);
        chk("mid_grant_noack", 64'(host_ack), 0);
        step();
        reset = 1'b1;
        @(negedge clk);
        chk("mid_rst_ack", 64'(host_ack), 0);
        chk("mid_rst_wea", 64'(ram_wea), 0);
        step();
        host_req = 1'b0; host_clear = 1'b0;
        step();
        reset = 1'b0;
        do_init("reinit");
        nz = 0;
        for (int i = 0; i < DEPTH; i++) if (mem[i] !== '0) nz++;
        chk("reinit_all_zero", 64'(nz), 0);
        host_rd_chk("rd6", 6, 0);
        host_rd_chk("rd7b", 7, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
